// File: rtl/axil_dmem_if.sv
// rtl/axil_dmem_if.sv - AXI-lite style load/store channel bundle for axil_dmem
//
// Purpose: groups the AR/R and AW/W/B channels between the memory-access
// stage (master) and the data memory (slave).
// Signals:
//   arvalid/arready/araddr          read address channel
//   rvalid/rready/rdata/rresp       read data channel
//   awvalid/awready/awaddr          write address channel
//   wvalid/wready/wdata/wstrb       write data channel (wstrb[7:4] unused)
//   bvalid/bready/bresp             write response channel
interface axil_dmem_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport slave (
    input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );

  modport master (
    output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axil_dmem.sv
// rtl/axil_dmem.sv - word-organised data memory slave with programmable latency
//
// Purpose: terminates the load/store channels of the multicycle core and
// answers them from a 32-bit word array after READ_LAT / WRITE_LAT wait
// cycles. Out-of-range accesses answer SLVERR without touching the array.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (array contents are kept)
//   bus  - axil_dmem_if.slave: AR/R and AW/W/B channels
module axil_dmem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned WRITE_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  axil_dmem_if.slave bus
);
  localparam int unsigned IW   = $clog2(DEPTH_WORDS);
  localparam int unsigned CW   = 16;
  localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) << 2;
  localparam logic [CW-1:0] RL_C = CW'(READ_LAT);
  localparam logic [CW-1:0] WL_C = CW'(WRITE_LAT);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH_WORDS];

  // read channel
  r_state_t      r_state, r_state_n;
  logic [CW-1:0] r_cnt, r_cnt_n;
  logic [31:0]   ar_addr_q, r_samp_addr, r_off;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic          r_sample, ar_take, r_hit;

  // write channel
  w_state_t      w_state, w_state_n;
  logic [CW-1:0] w_cnt, w_cnt_n;
  logic          aw_got, aw_got_n, w_got, w_got_n;
  logic          aw_hs, w_hs, w_commit, w_hit;
  logic [31:0]   aw_addr_q, w_data_q, w_addr_eff, w_data_eff, w_off;
  logic [3:0]    w_strb_q, w_strb_eff;
  logic [1:0]    bresp_q;

  // Offsets wrap below BASE_ADDR, so a single unsigned compare covers both bounds.
  assign r_off = r_samp_addr - BASE_ADDR;
  assign r_hit = {32'd0, r_off} < SPAN;
  assign w_off = w_addr_eff - BASE_ADDR;
  assign w_hit = {32'd0, w_off} < SPAN;

  // With zero latency the commit/sample happens on the handshake edge itself,
  // so the live bus values stand in for the not-yet-captured registers.
  assign w_addr_eff = aw_got ? aw_addr_q : bus.awaddr;
  assign w_data_eff = w_got ? w_data_q : bus.wdata;
  assign w_strb_eff = w_got ? w_strb_q : bus.wstrb[3:0];

  logic unused_bits;
  assign unused_bits = ^{r_off[31:IW+2], r_off[1:0], w_off[31:IW+2], w_off[1:0], bus.wstrb[7:4]};

  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
  assign bus.bresp = bresp_q;

  always_comb begin
    r_state_n   = r_state;
    r_cnt_n     = r_cnt;
    r_sample    = 1'b0;
    r_samp_addr = ar_addr_q;
    ar_take     = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    if (!rst) begin
      case (r_state)
        R_IDLE: begin
          bus.arready = 1'b1;
          if (bus.arvalid) begin
            ar_take = 1'b1;
            if (READ_LAT == 0) begin
              r_sample    = 1'b1;
              r_samp_addr = bus.araddr;
              r_state_n   = R_RESP;
            end else begin
              r_cnt_n   = RL_C;
              r_state_n = R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt <= CW'(1)) begin
            r_sample  = 1'b1;
            r_state_n = R_RESP;
          end else begin
            r_cnt_n = r_cnt - CW'(1);
          end
        end
        R_RESP: begin
          bus.rvalid = 1'b1;
          if (bus.rready) r_state_n = R_IDLE;
        end
        default: r_state_n = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state <= r_state_n;
      r_cnt   <= r_cnt_n;
      if (ar_take) ar_addr_q <= bus.araddr;
      // Sampling here with a non-blocking read gives read-before-write on a
      // same-edge commit to the same word.
      if (r_sample) begin
        rdata_q <= r_hit ? mem[r_off[IW+1:2]] : '0;
        rresp_q <= r_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_comb begin
    w_state_n   = w_state;
    w_cnt_n     = w_cnt;
    aw_got_n    = aw_got;
    w_got_n     = w_got;
    aw_hs       = 1'b0;
    w_hs        = 1'b0;
    w_commit    = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    if (!rst) begin
      case (w_state)
        W_COLLECT: begin
          bus.awready = !aw_got;
          bus.wready  = !w_got;
          aw_hs       = !aw_got && bus.awvalid;
          w_hs        = !w_got && bus.wvalid;
          aw_got_n    = aw_got || aw_hs;
          w_got_n     = w_got || w_hs;
          if (aw_got_n && w_got_n) begin
            if (WRITE_LAT == 0) begin
              w_commit  = 1'b1;
              w_state_n = W_RESP;
            end else begin
              w_cnt_n   = WL_C;
              w_state_n = W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (w_cnt <= CW'(1)) begin
            w_commit  = 1'b1;
            w_state_n = W_RESP;
          end else begin
            w_cnt_n = w_cnt - CW'(1);
          end
        end
        W_RESP: begin
          bus.bvalid = 1'b1;
          if (bus.bready) begin
            aw_got_n  = 1'b0;
            w_got_n   = 1'b0;
            w_state_n = W_COLLECT;
          end
        end
        default: w_state_n = W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_COLLECT;
      w_cnt     <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= '0;
    end else begin
      w_state <= w_state_n;
      w_cnt   <= w_cnt_n;
      aw_got  <= aw_got_n;
      w_got   <= w_got_n;
      if (aw_hs) aw_addr_q <= bus.awaddr;
      if (w_hs) begin
        w_data_q <= bus.wdata;
        w_strb_q <= bus.wstrb[3:0];
      end
      if (w_commit) bresp_q <= w_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // The array has no reset; w_commit is already held low during rst.
  always_ff @(posedge clk) begin
    if (w_commit && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb_eff[b]) mem[w_off[IW+1:2]][8*b +: 8] <= w_data_eff[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axil_dmem.sv
// tb/tb_axil_dmem.sv - randomized self-checking bench for axil_dmem
module tb_axil_dmem;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int RL = 2;
  localparam int WL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_dmem_if bus();

  axil_dmem #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .READ_LAT   (RL),
    .WRITE_LAT  (WL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mdl [int];
  logic [3:0]  mknown [int];

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction

  bit          m_rpend = 0;
  int          m_rdue  = 0;
  logic [31:0] m_raddr = '0;
  logic [31:0] m_rdata = '0;
  logic [3:0]  m_rknown = '0;
  logic [1:0]  m_rresp = '0;
  bit          m_awhave = 0, m_whave = 0, m_wbusy = 0;
  int          m_wdue = 0;
  logic [31:0] m_waddr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic [1:0]  m_bresp = '0;

  always @(posedge clk) begin
    bit ex_rv, ex_bv, ex_ar, ex_aw, ex_w;
    int w;
    logic [31:0] tmp;
    if (rst) begin
      m_rpend = 0; m_awhave = 0; m_whave = 0; m_wbusy = 0;
      m_rresp = '0; m_bresp = '0; m_rdata = '0; m_rknown = 4'hF;
    end else begin
      ex_rv = m_rpend && (cyc >= m_rdue);
      ex_bv = m_wbusy && (cyc >= m_wdue);
      ex_ar = !m_rpend;
      ex_aw = !m_awhave;
      ex_w  = !m_whave;
      if (ex_rv && bus.rready) m_rpend = 0;
      else if (ex_ar && bus.arvalid) begin
        m_rpend = 1; m_rdue = cyc + 1 + RL; m_raddr = bus.araddr;
      end
      // read sample precedes any same-edge write commit
      if (m_rpend && m_rdue == cyc + 1) begin
        if (!in_rng(m_raddr)) begin
          m_rdata = '0; m_rknown = 4'hF; m_rresp = 2'b10;
        end else begin
          w = word_of(m_raddr);
          m_rresp = 2'b00;
          if (mknown.exists(w)) begin m_rdata = mdl[w]; m_rknown = mknown[w]; end
          else begin m_rdata = '0; m_rknown = 4'h0; end
        end
      end
      if (ex_bv && bus.bready) begin
        m_awhave = 0; m_whave = 0; m_wbusy = 0;
      end else begin
        if (ex_aw && bus.awvalid) begin m_awhave = 1; m_waddr = bus.awaddr; end
        if (ex_w && bus.wvalid) begin m_whave = 1; m_wdata = bus.wdata; m_wstrb = bus.wstrb[3:0]; end
        if (m_awhave && m_whave && !m_wbusy) begin m_wbusy = 1; m_wdue = cyc + 1 + WL; end
        if (m_wbusy && m_wdue == cyc + 1) begin
          if (in_rng(m_waddr)) begin
            w = word_of(m_waddr);
            if (!mknown.exists(w)) begin mdl[w] = '0; mknown[w] = 4'h0; end
            tmp = mdl[w];
            for (int b = 0; b < 4; b++) if (m_wstrb[b]) tmp[8*b +: 8] = m_wdata[8*b +: 8];
            mdl[w] = tmp;
            mknown[w] = mknown[w] | m_wstrb;
            m_bresp = 2'b00;
          end else begin
            m_bresp = 2'b10;
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit e_rv, e_bv;
    logic [31:0] mk;
    e_rv = !rst && m_rpend && (cyc >= m_rdue);
    e_bv = !rst && m_wbusy && (cyc >= m_wdue);
    chk("arready", 32'(bus.arready), 32'(!rst && !m_rpend));
    chk("awready", 32'(bus.awready), 32'(!rst && !m_awhave));
    chk("wready",  32'(bus.wready),  32'(!rst && !m_whave));
    chk("rvalid",  32'(bus.rvalid),  32'(e_rv));
    chk("bvalid",  32'(bus.bvalid),  32'(e_bv));
    if (rst) begin
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_rresp", 32'(bus.rresp), 32'd0);
      chk("rst_bresp", 32'(bus.bresp), 32'd0);
    end else begin
      if (e_rv) begin
        mk = bmask(m_rknown);
        chk("rdata", bus.rdata & mk, m_rdata & mk);
        chk("rresp", 32'(bus.rresp), 32'(m_rresp));
      end
      if (e_bv) chk("bresp", 32'(bus.bresp), 32'(m_bresp));
    end
  end

  // ---------------- drivers (start and end at posedge + 1) ----------------
  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] d, output logic [1:0] rs, output int lat);
    int t_ar, t_rv;
    t_ar = -1; t_rv = -1; d = '0; rs = '0; lat = -1;
    bus.arvalid = 1'b1; bus.araddr = a;
    for (int i = 0; i < 100 && t_ar < 0; i++) begin
      @(negedge clk);
      if (bus.arready) t_ar = cyc;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    chk("ar_handshake_seen", 32'(t_ar >= 0), 32'd1);
    if (t_ar < 0) return;
    for (int i = 0; i < 100 && t_rv < 0; i++) begin
      @(negedge clk);
      if (bus.rvalid) t_rv = cyc;
      else begin @(posedge clk); #1; end
    end
    chk("rvalid_seen", 32'(t_rv >= 0), 32'd1);
    if (t_rv < 0) return;
    repeat (hold) @(negedge clk);
    d = bus.rdata; rs = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    lat = t_rv - t_ar;
  endtask

  // w_lead > 0: W is presented that many cycles before AW; < 0: AW leads.
  task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [7:0] s,
                          input int w_lead, input int bhold, output logic [1:0] br, output int lat);
    int t_aw, t_w, t_b;
    t_aw = -1; t_w = -1; t_b = -1; br = '0; lat = -1;
    bus.awaddr = a; bus.wdata = dat; bus.wstrb = s;
    for (int i = 0; i < 100 && (t_aw < 0 || t_w < 0); i++) begin
      bus.awvalid = (t_aw < 0) && (i >= w_lead);
      bus.wvalid  = (t_w < 0) && (i >= -w_lead);
      @(negedge clk);
      if (bus.awvalid && bus.awready) t_aw = cyc;
      if (bus.wvalid && bus.wready) t_w = cyc;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("aw_w_handshake_seen", 32'(t_aw >= 0 && t_w >= 0), 32'd1);
    if (t_aw < 0 || t_w < 0) return;
    for (int i = 0; i < 100 && t_b < 0; i++) begin
      @(negedge clk);
      if (bus.bvalid) t_b = cyc;
      else begin @(posedge clk); #1; end
    end
    chk("bvalid_seen", 32'(t_b >= 0), 32'd1);
    if (t_b < 0) return;
    repeat (bhold) @(negedge clk);
    br = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    lat = t_b - ((t_aw > t_w) ? t_aw : t_w);
  endtask

  function automatic logic [31:0] rnd_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8) return BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
    if (k == 8) return BASE - 32'd4;
    return BASE + 32'(4 * DEPTH);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  rs, rs2, br;
    int lr, lw;
    bus.arvalid = 1'b1; bus.araddr = BASE; bus.rready = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
    rst = 1'b1;

    // reset held 3 cycles with arvalid high
    @(posedge clk);
    @(negedge clk);
    chk("reset_arready", 32'(bus.arready), 32'd0);
    chk("reset_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; bus.arvalid = 1'b0;
    @(negedge clk);
    chk("post_reset_arready", 32'(bus.arready), 32'd1);
    chk("post_reset_awready", 32'(bus.awready), 32'd1);
    chk("post_reset_wready", 32'(bus.wready), 32'd1);
    @(posedge clk); #1;

    // write then read
    do_write(BASE + 32'h10, 32'hDEADBEEF, 8'h0F, 0, 0, br, lw);
    chk("wr_latency", 32'(lw), 32'd3);
    chk("wr_bresp", 32'(br), 32'd0);
    do_read(BASE + 32'h10, 0, d, rs, lr);
    chk("rd_latency", 32'(lr), 32'd3);
    chk("rd_data", d, 32'hDEADBEEF);
    chk("rd_rresp", 32'(rs), 32'd0);

    // byte strobes, upper nibble ignored
    do_write(BASE + 32'h20, 32'h11223344, 8'h0F, 0, 0, br, lw);
    do_write(BASE + 32'h20, 32'hAABBCCDD, 8'hF5, 0, 0, br, lw);
    do_read(BASE + 32'h20, 0, d, rs, lr);
    chk("strobe_merge", d, 32'h11BB33DD);

    // W two cycles ahead of AW
    do_write(BASE + 32'h30, 32'h0BADF00D, 8'h0F, 2, 0, br, lw);
    chk("w_first_latency", 32'(lw), 32'd3);
    do_read(BASE + 32'h30, 0, d, rs, lr);
    chk("w_first_data", d, 32'h0BADF00D);

    // out of range
    do_read(32'h7FFF_FFFC, 0, d, rs, lr);
    chk("oor_rresp", 32'(rs), 32'd2);
    chk("oor_rdata", d, 32'd0);
    do_write(BASE, 32'h01234567, 8'h0F, 0, 0, br, lw);
    do_write(32'h8000_4000, 32'hFFFFFFFF, 8'h0F, -1, 0, br, lw);
    chk("oor_bresp", 32'(br), 32'd2);
    do_read(BASE, 0, d, rs, lr);
    chk("oor_word0_kept", d, 32'h01234567);

    // back-pressure on R and B
    do_write(BASE + 32'h40, 32'hCAFEF00D, 8'h0F, 0, 4, br, lw);
    chk("bp_bresp", 32'(br), 32'd0);
    do_read(BASE + 32'h40, 5, d, rs, lr);
    chk("bp_rdata", d, 32'hCAFEF00D);
    chk("bp_latency", 32'(lr), 32'd3);

    // read sample and write commit on the same edge, same word
    do_write(BASE + 32'h50, 32'h55555555, 8'h0F, 0, 0, br, lw);
    fork
      do_read(BASE + 32'h50, 0, d, rs, lr);
      do_write(BASE + 32'h50, 32'hAAAAAAAA, 8'h0F, 0, 0, br, lw);
    join
    chk("collide_rd_lat", 32'(lr), 32'd3);
    chk("collide_wr_lat", 32'(lw), 32'd3);
    chk("collide_old", d, 32'h55555555);
    do_read(BASE + 32'h50, 0, d, rs, lr);
    chk("collide_new", d, 32'hAAAAAAAA);

    // randomized traffic over a small window, checked by the model
    for (int k = 0; k < 8; k++) do_write(BASE + 32'(4 * k), $urandom, 8'h0F, 0, 0, br, lw);
    for (int it = 0; it < 250; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_read(rnd_addr(), $urandom_range(0, 3), d, rs, lr);
      end else if (op == 1) begin
        do_write(rnd_addr(), $urandom, 8'($urandom), $urandom_range(0, 4) - 2,
                 $urandom_range(0, 3), br, lw);
      end else begin
        fork
          do_read(rnd_addr(), $urandom_range(0, 3), d2, rs2, lr);
          do_write(rnd_addr(), $urandom, 8'($urandom), $urandom_range(0, 4) - 2,
                   $urandom_range(0, 3), br, lw);
        join
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axil_dmem.md
# axil_dmem

Data-memory slave for the multicycle core. Sits directly downstream of the write-back/memory-access stage and terminates its AXI-lite style load/store channels (AR/R, AW/W/B). Holds a word-organised SRAM model with programmable access latency, so the stage's `mem_finish` handshaking is exercised with real multi-cycle responses.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, default 32'h8000_0000: byte address of word 0.
- `READ_LAT`, default 2: wait cycles between AR acceptance and `rvalid`; 0 is legal.
- `WRITE_LAT`, default 2: wait cycles between the capture of both AW and W and `bvalid`; 0 is legal.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `arvalid` in 1, `arready` out 1, `araddr` in 32: read address channel.
- `rvalid` out 1, `rready` in 1, `rdata` out 32, `rresp` out 2: read data channel.
- `awvalid` in 1, `awready` out 1, `awaddr` in 32: write address channel.
- `wvalid` in 1, `wready` in… `wready` out 1, `wdata` in 32, `wstrb` in 8: write data channel. Only bits [3:0] of `wstrb` are used; bits [7:4] are ignored.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response channel.

## Operation
- **Address decode**
  - Word index = `(addr - BASE_ADDR) >> 2`, truncated to log2(DEPTH_WORDS) bits.
  - In range means `BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS`. `addr[1:0]` is ignored.
  - Out-of-range access gives resp 2'b10 (SLVERR). For reads, `rdata` is 0. For writes, no array update.
  - In-range access gives resp 2'b00.
- **Read FSM: R_IDLE → R_WAIT → R_RESP**
  - R_IDLE: `arready`=1. On `arvalid`, capture `araddr`, load the counter with READ_LAT, and go to R_WAIT. If READ_LAT=0, go straight to R_RESP.
  - R_WAIT: decrement the counter. When it reaches 1, sample the array into the `rdata` register and go to R_RESP.
  - R_RESP: `rvalid`=1. `rdata`/`rresp` are stable until `rready`. On `rvalid && rready`, return to R_IDLE.
- **Write FSM: W_COLLECT → W_WAIT → W_RESP**
  - W_COLLECT: `awready`=1 until AW is captured. `wready`=1 until W is captured.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are captured: go to W_WAIT with the counter set to WRITE_LAT, or go straight to W_RESP if WRITE_LAT=0.
  - The array write (byte lanes per `wstrb[3:0]`) commits on the transition into W_RESP.
  - W_RESP: `bvalid`=1 until `bready`. Then clear both capture flags and return to W_COLLECT.
- Read and write channels are fully independent and may be in flight at the same time.
- Same word, same cycle (read sample coincides with write commit): the read returns the old data (read-before-write).
- Only one outstanding transaction per channel; no pipelining.
- Array contents are not initialised and not cleared by reset.

## Timing
- **During `rst`=1:**
  - All FSMs go to IDLE/COLLECT, counters clear, capture flags clear.
  - `arready`, `awready`, `wready`, `rvalid`, `bvalid` = 0.
  - `rdata`, `rresp`, `bresp` = 0.
- **First cycle after reset release:** `arready`=`awready`=`wready`=1.
- **Read latency:** AR handshake in cycle T gives `rvalid` first high in cycle T+1+READ_LAT.
- **Write latency:** the later of the AW/W handshakes in cycle T gives memory updated and `bvalid` high in cycle T+1+WRITE_LAT.
- **Back-pressure:** `rvalid`/`bvalid` stay asserted indefinitely while `rready`/`bready` are low, with data/resp held constant.
- **No ready-to-new-address bypass:** the next AR is accepted at the earliest one cycle after the R handshake, when `arready` returns to 1.
- **Reset mid-transaction:** the transaction is abandoned, no response is issued, and a pending write does not commit unless the commit edge has already occurred.
- **Ready independence:** `arready`/`awready`/`wready` depend only on state, never combinationally on the valid inputs.

## Test plan
- **Reset:** hold `rst` 3 cycles with `arvalid`=1 → no handshake, all valids 0. One cycle after release, `arready`=1.
- **Write then read:** write 32'hDEADBEEF to 0x8000_0010 with `wstrb`=8'h0F, then read 0x8000_0010. Required: `bvalid` at T+3, `rdata`=32'hDEADBEEF at AR+3, `rresp`=0 (READ_LAT=WRITE_LAT=2).
- **Byte strobes:** preload 32'h11223344, write 32'hAABBCCDD with `wstrb`=8'hF5 (upper nibble ignored) → readback 32'h11BB33DD.
- **W before AW:** present W two cycles before AW → W captured first; `bvalid` at AW+3; data correct.
- **Out of range:** read at 0x7FFF_FFFC → `rresp`=2'b10, `rdata`=0. Write at 0x8000_4000 → `bresp`=2'b10, and word 0 is unchanged.
- **Back-pressure and collision:** hold `rready` low for 5 cycles → `rvalid`/`rdata` stable. Separately, align a read sample with a write commit to the same word → the read returns the old value and a following read returns the new one.
